// File: rtl/dca_matrix_row_pingpong.sv
// dca_matrix_row_pingpong: two-bank ping-pong buffer collecting tensor rows into whole matrices
//
// Ports:
//   clk                     rising-edge clock
//   rstnn                   asynchronous active-low reset
//   clear                   synchronous soft clear, overrides every other event
//   load_tensor_row_wvalid  row valid from the matrix LSU
//   load_tensor_row_wlast   row is the last of its matrix
//   load_tensor_row_wdata   row payload
//   load_tensor_row_wready  row accepted this cycle (fill bank not full, no clear)
//   matrix_valid            read bank holds a complete matrix
//   matrix_release          consumer is done with the read bank
//   rd_index                row select into the read bank
//   rd_data                 registered row of the read bank, zero when invalid or unwritten
//   busy                    some bank is full or a fill is in progress
//   error_last              sticky flag: wlast disagreed with the row count
module dca_matrix_row_pingpong #(
  parameter int BW_TENSOR_ROW = 64,
  parameter int NUM_ROW = 8,
  parameter int BW_INDEX = 4
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     load_tensor_row_wvalid,
  input  logic                     load_tensor_row_wlast,
  input  logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata,
  output logic                     load_tensor_row_wready,
  output logic                     matrix_valid,
  input  logic                     matrix_release,
  input  logic [BW_INDEX-1:0]      rd_index,
  output logic [BW_TENSOR_ROW-1:0] rd_data,
  output logic                     busy,
  output logic                     error_last
);
  localparam int IW = $clog2(NUM_ROW);
  localparam logic [BW_INDEX-1:0] LAST_ROW = BW_INDEX'(NUM_ROW - 1);
  localparam logic [BW_INDEX:0] ROWS = (BW_INDEX + 1)'(NUM_ROW);
  logic [BW_TENSOR_ROW-1:0] r_mem [2][NUM_ROW];
  logic [NUM_ROW-1:0]       r_mask [2];
  logic                     r_wbank;
  logic                     r_rbank;
  logic [BW_INDEX-1:0]      r_wrow;
  logic [1:0]               r_full;
  logic                     r_err;
  logic [BW_TENSOR_ROW-1:0] r_rd_data;
  logic                     w_accept;
  logic                     w_last_row;
  logic                     w_close;
  logic                     w_release;
  logic                     w_rd_hit;
  logic [NUM_ROW-1:0]       w_row_bit;
  logic [NUM_ROW-1:0]       w_rd_mask;
  logic [1:0]               w_full_nxt;
  assign load_tensor_row_wready = !r_full[r_wbank] && !clear;
  assign matrix_valid = r_full[r_rbank];
  assign busy = (|r_full) || (r_wrow != '0);
  assign error_last = r_err;
  assign rd_data = r_rd_data;
  assign w_accept = load_tensor_row_wvalid && load_tensor_row_wready;
  assign w_last_row = r_wrow == LAST_ROW;
  assign w_close = w_accept && (load_tensor_row_wlast || w_last_row);
  assign w_release = matrix_release && matrix_valid;
  assign w_row_bit = NUM_ROW'(1) << r_wrow;
  assign w_rd_mask = r_mask[r_rbank] >> rd_index;
  assign w_rd_hit = matrix_valid && ({1'b0, rd_index} < ROWS) && w_rd_mask[0];
  // close and release always target different banks, so both updates compose
  assign w_full_nxt = (r_full | ({1'b0, w_close} << r_wbank)) & ~({1'b0, w_release} << r_rbank);
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wbank][r_wrow[IW-1:0]] <= load_tensor_row_wdata;
  end
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_wbank   <= 1'b0;
      r_rbank   <= 1'b0;
      r_wrow    <= '0;
      r_full    <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_mask[0] <= '0;
      r_mask[1] <= '0;
    end else if (clear) begin
      r_wbank   <= 1'b0;
      r_rbank   <= 1'b0;
      r_wrow    <= '0;
      r_full    <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_mask[0] <= '0;
      r_mask[1] <= '0;
    end else begin
      if (w_accept) begin
        // the first row of a fill discards whatever the previous matrix left in the mask
        r_mask[r_wbank] <= (r_wrow == '0) ? w_row_bit : (r_mask[r_wbank] | w_row_bit);
        r_wrow          <= w_close ? '0 : r_wrow + 1'b1;
        r_wbank         <= r_wbank ^ w_close;
        r_err           <= r_err | (load_tensor_row_wlast != w_last_row);
      end
      r_full    <= w_full_nxt;
      r_rbank   <= r_rbank ^ w_release;
      r_rd_data <= w_rd_hit ? r_mem[r_rbank][rd_index[IW-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_dca_matrix_row_pingpong.sv
// tb_dca_matrix_row_pingpong: directed vector table plus hand sequences for the ping-pong row buffer
module tb_dca_matrix_row_pingpong;
  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        clear = 1'b0;
  logic        wvalid = 1'b0;
  logic        wlast = 1'b0;
  logic [63:0] wdata = '0;
  logic        wready;
  logic        mvalid;
  logic        release_i = 1'b0;
  logic [3:0]  rd_index = '0;
  logic [63:0] rd_data;
  logic        busy;
  logic        err;
  int          n_checks = 0;
  int          n_errors = 0;
  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] d;
    logic       rel;
    logic [3:0] idx;
    logic       clr;
    logic       e_wr;
    logic       e_mv;
    logic [7:0] e_rd;
    logic       e_b;
    logic       e_err;
  } vec_t;
  vec_t tbl [26];
  always #5 clk = ~clk;
  dca_matrix_row_pingpong dut (
    .clk                    (clk),
    .rstnn                  (rstnn),
    .clear                  (clear),
    .load_tensor_row_wvalid (wvalid),
    .load_tensor_row_wlast  (wlast),
    .load_tensor_row_wdata  (wdata),
    .load_tensor_row_wready (wready),
    .matrix_valid           (mvalid),
    .matrix_release         (release_i),
    .rd_index               (rd_index),
    .rd_data                (rd_data),
    .busy                   (busy),
    .error_last             (err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic v, l, input logic [7:0] d, input logic rel,
                              input logic [3:0] idx, input logic clr, input logic e_wr, e_mv,
                              input logic [7:0] e_rd, input logic e_b, e_err);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.rel = rel; t.idx = idx; t.clr = clr;
    t.e_wr = e_wr; t.e_mv = e_mv; t.e_rd = e_rd; t.e_b = e_b; t.e_err = e_err;
    return t;
  endfunction
  initial begin
    //            v  l  d      rel idx clr  wr mv rd     b  err
    tbl[0]  = mk(1, 0, 8'h10, 0, 0, 0,   1, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 8'h11, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[2]  = mk(1, 0, 8'h12, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[3]  = mk(1, 0, 8'h13, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[4]  = mk(1, 0, 8'h14, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[5]  = mk(1, 0, 8'h15, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[6]  = mk(1, 0, 8'h16, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[7]  = mk(1, 1, 8'h17, 0, 0, 0,   1, 0, 8'h00, 1, 0);
    tbl[8]  = mk(0, 0, 8'h00, 0, 3, 0,   1, 1, 8'h00, 1, 0);
    tbl[9]  = mk(0, 0, 8'h00, 0, 3, 0,   1, 1, 8'h13, 1, 0);
    tbl[10] = mk(1, 0, 8'h20, 0, 7, 0,   1, 1, 8'h13, 1, 0);
    tbl[11] = mk(1, 0, 8'h21, 0, 0, 0,   1, 1, 8'h17, 1, 0);
    tbl[12] = mk(1, 0, 8'h22, 0, 8, 0,   1, 1, 8'h10, 1, 0);
    tbl[13] = mk(1, 0, 8'h23, 0, 3, 0,   1, 1, 8'h00, 1, 0);
    tbl[14] = mk(1, 1, 8'h24, 0, 3, 0,   1, 1, 8'h13, 1, 0);
    tbl[15] = mk(0, 0, 8'h00, 1, 3, 0,   0, 1, 8'h13, 1, 1);
    tbl[16] = mk(0, 0, 8'h00, 0, 6, 0,   1, 1, 8'h13, 1, 1);
    tbl[17] = mk(0, 0, 8'h00, 0, 4, 0,   1, 1, 8'h00, 1, 1);
    tbl[18] = mk(0, 0, 8'h00, 0, 0, 0,   1, 1, 8'h24, 1, 1);
    tbl[19] = mk(1, 0, 8'h30, 0, 1, 0,   1, 1, 8'h20, 1, 1);
    tbl[20] = mk(1, 0, 8'h31, 0, 2, 0,   1, 1, 8'h21, 1, 1);
    tbl[21] = mk(1, 1, 8'h32, 1, 0, 0,   1, 1, 8'h22, 1, 1);
    tbl[22] = mk(0, 0, 8'h00, 0, 2, 0,   1, 1, 8'h20, 1, 1);
    tbl[23] = mk(0, 0, 8'h00, 0, 3, 0,   1, 1, 8'h32, 1, 1);
    tbl[24] = mk(0, 0, 8'h00, 0, 0, 1,   0, 1, 8'h00, 1, 1);
    tbl[25] = mk(0, 0, 8'h00, 0, 0, 0,   1, 0, 8'h00, 0, 0);
    #1;
    chk("rst_wready", 64'(wready), 64'd1);
    chk("rst_mvalid", 64'(mvalid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    for (int i = 0; i < 26; i++) begin
      wvalid = tbl[i].v;
      wlast = tbl[i].l;
      wdata = {56'h0, tbl[i].d};
      release_i = tbl[i].rel;
      rd_index = tbl[i].idx;
      clear = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_wready", i), 64'(wready), 64'(tbl[i].e_wr));
      chk($sformatf("v%0d_mvalid", i), 64'(mvalid), 64'(tbl[i].e_mv));
      chk($sformatf("v%0d_rd_data", i), rd_data, {56'h0, tbl[i].e_rd});
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].e_b));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].e_err));
      @(negedge clk);
    end
    clear = 1'b0;
    rd_index = '0;
    for (int i = 0; i < 17; i++) begin
      wvalid = 1'b1;
      wlast = (i == 7) || (i == 15);
      wdata = 64'h40 + 64'(i);
      #1;
      chk($sformatf("bp_wready_row%0d", i + 1), 64'(wready), 64'(i < 16));
      @(negedge clk);
    end
    release_i = 1'b1;
    #1;
    chk("bp_wready_held", 64'(wready), 64'd0);
    chk("bp_mvalid_full", 64'(mvalid), 64'd1);
    @(negedge clk);
    release_i = 1'b0;
    #1;
    chk("bp_wready_after_rel", 64'(wready), 64'd1);
    chk("bp_mvalid_bank1", 64'(mvalid), 64'd1);
    chk("bp_err", 64'(err), 64'd0);
    @(negedge clk);
    wvalid = 1'b1;
    wdata = 64'h51;
    #1;
    chk("bp_busy", 64'(busy), 64'd1);
    @(negedge clk);
    wdata = 64'h52;
    #1;
    chk("bp_rd_bank1_row0", rd_data, 64'h48);
    @(negedge clk);
    wvalid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clr_wready_low", 64'(wready), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_mvalid", 64'(mvalid), 64'd0);
    chk("clr_wready", 64'(wready), 64'd1);
    chk("clr_err", 64'(err), 64'd0);
    for (int i = 0; i < 10; i++) begin
      wvalid = 1'b1;
      wlast = (i == 7);
      wdata = 64'h70 + 64'(i);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rstnn = 1'b0;
    #1;
    chk("arst_wready", 64'(wready), 64'd1);
    chk("arst_mvalid", 64'(mvalid), 64'd0);
    chk("arst_rd_data", rd_data, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    wvalid = 1'b1;
    wlast = 1'b1;
    wdata = 64'h60;
    @(negedge clk);
    wvalid = 1'b0;
    wlast = 1'b0;
    rd_index = 4'd1;
    #1;
    chk("post_rst_mvalid", 64'(mvalid), 64'd1);
    chk("post_rst_err", 64'(err), 64'd1);
    @(negedge clk);
    rd_index = 4'd0;
    #1;
    chk("post_rst_stale_row1", rd_data, 64'd0);
    @(negedge clk);
    #1;
    chk("post_rst_row0", rd_data, 64'h60);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
